rv32i_multicycle_core: RTL and testbench

Multi-cycle RV32I processor core, parametrised in reset vector and register count (RV32I or RV32E). It executes each instruction through a fetch/decode/execute/memory/write-back state machine. Instruction and data accesses share one unified memory port with a valid/ready handshake, so the core tolerates any memory latency. Unlike a single-cycle core, it supports byte/halfword loads and stores, JAL/JALR, and precise halting on illegal, misaligned or ECALL/EBREAK instructions.

---
 rtl/rv32i_multicycle_core.sv | 259 +++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_core.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: one unified valid/ready memory port for both
// instruction fetch and data, and a halt with a cause code on any fault.
module rv32i_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  halt_cause,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);
    localparam bit          RV32E = (NUM_REGS == 16);
    localparam int unsigned AW    = RV32E ? 4 : 5;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    state_t state, next_state;

    logic [31:0] regs [NUM_REGS];
    logic [31:0] op_a, op_b, imm, wb_val, npc;
    logic [1:0]  ea_lo;

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = instr_out[6:0];
    assign rd     = instr_out[11:7];
    assign f3     = instr_out[14:12];
    assign rs1    = instr_out[19:15];
    assign rs2    = instr_out[24:20];
    assign f7     = instr_out[31:25];

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_reg;
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_reg    = (opcode == OP_REG);

    // Decode: legality, trap detection, register index range, immediate
    logic legal, trap, bad_idx, wr_rd;
    logic [31:0] imm_d;
    assign trap    = (instr_out == 32'h0000_0073) || (instr_out == 32'h0010_0073);
    assign bad_idx = RV32E & ((!(is_lui | is_auipc | is_jal) & rs1[4]) |
                              ((is_branch | is_store | is_reg) & rs2[4]) |
                              (!(is_branch | is_store) & rd[4]));
    assign wr_rd   = !(is_branch || is_store);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:   legal = (f3 == 3'b000);
            OP_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
            OP_LOAD:   legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            OP_STORE:  legal = (f3 < 3'b011);
            OP_IMM: begin
                case (f3)
                    3'b001:  legal = (f7 == 7'b0000000);
                    3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OP_REG: legal = (f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        imm_d = {{20{instr_out[31]}}, instr_out[31:20]};
        case (opcode)
            OP_STORE:  imm_d = {{20{instr_out[31]}}, instr_out[31:25], instr_out[11:7]};
            OP_BRANCH: imm_d = {{19{instr_out[31]}}, instr_out[31], instr_out[7],
                                instr_out[30:25], instr_out[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm_d = {instr_out[31:12], 12'h000};
            OP_JAL:    imm_d = {{11{instr_out[31]}}, instr_out[31], instr_out[19:12],
                                instr_out[20], instr_out[30:21], 1'b0};
            default:   imm_d = {{20{instr_out[31]}}, instr_out[31:20]};
        endcase
    end

    // Execute: ALU, branch condition, targets, effective address, alignment
    logic [31:0] alu_b, alu_res, ea, target, pc_imm, pc_plus4, exec_val, exec_npc;
    logic        br_cond, taken, misaligned;
    assign alu_b    = (is_reg || is_branch) ? op_b : imm;
    assign ea       = op_a + imm;
    assign pc_imm   = pc_out + imm;
    assign pc_plus4 = pc_out + 32'd4;

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000: alu_res = (is_reg && instr_out[30]) ? op_a - alu_b : op_a + alu_b;
            3'b001: alu_res = op_a << alu_b[4:0];
            3'b010: alu_res = {31'd0, $signed(op_a) < $signed(alu_b)};
            3'b011: alu_res = {31'd0, op_a < alu_b};
            3'b100: alu_res = op_a ^ alu_b;
            3'b101: alu_res = instr_out[30] ? 32'($signed(op_a) >>> alu_b[4:0])
                                            : op_a >> alu_b[4:0];
            3'b110: alu_res = op_a | alu_b;
            default: alu_res = op_a & alu_b;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (f3)
            3'b000:  br_cond = (op_a == op_b);
            3'b001:  br_cond = (op_a != op_b);
            3'b100:  br_cond = $signed(op_a) < $signed(op_b);
            3'b101:  br_cond = $signed(op_a) >= $signed(op_b);
            3'b110:  br_cond = op_a < op_b;
            default: br_cond = op_a >= op_b;
        endcase
    end

    assign taken      = is_jal || is_jalr || (is_branch && br_cond);
    assign target     = is_jalr ? {ea[31:1], 1'b0} : pc_imm;
    assign exec_npc   = taken ? target : pc_plus4;
    assign exec_val   = is_lui ? imm : is_auipc ? pc_imm : (is_jal || is_jalr) ? pc_plus4 : alu_res;
    assign misaligned = (taken && (target[1:0] != 2'b00)) ||
                        ((is_load || is_store) &&
                         (((f3[1:0] == 2'b01) && ea[0]) || ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00))));

    // Store lane placement and load lane extraction
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_sh, ld_val;
    assign ld_sh = mem_rdata >> {ea_lo, 3'b000};

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = op_b;
        case (f3[1:0])
            2'b00: begin st_be = 4'b0001 << ea[1:0]; st_wdata = {4{op_b[7:0]}}; end
            2'b01: begin st_be = 4'b0011 << ea[1:0]; st_wdata = {2{op_b[15:0]}}; end
            default: begin st_be = 4'b1111; st_wdata = op_b; end
        endcase
    end

    always_comb begin
        ld_val = ld_sh;
        case (f3)
            3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_val = {24'd0, ld_sh[7:0]};
            3'b101:  ld_val = {16'd0, ld_sh[15:0]};
            default: ld_val = ld_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_req && mem_ready) next_state = S_DECODE;
            S_DECODE: next_state = (trap || !legal || bad_idx) ? S_HALT : S_EXEC;
            S_EXEC:   next_state = misaligned ? S_HALT : (is_load || is_store) ? S_MEM : S_WB;
            S_MEM:    if (mem_req && mem_ready) next_state = S_WB;
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_HALT;
        endcase
    end

    // Next values of the registered handshake/status outputs
    logic       mem_req_d, retire_d, halted_d;
    logic [1:0] cause_d;
    always_comb begin
        mem_req_d = (next_state == S_FETCH) || (next_state == S_MEM);
        retire_d  = (next_state == S_WB);
        halted_d  = (next_state == S_HALT);
        cause_d   = halt_cause;
        case (state)
            S_DECODE: cause_d = trap ? 2'b01 : 2'b10;
            S_EXEC:   cause_d = 2'b11;
            default:  cause_d = halt_cause;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {RESET_PC[31:2], 2'b00};
            mem_be     <= 4'b1111;
            mem_wdata  <= '0;
            pc_out     <= RESET_PC;
            instr_out  <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            halt_cause <= 2'b00;
            op_a       <= '0;
            op_b       <= '0;
            imm        <= '0;
            wb_val     <= '0;
            npc        <= '0;
            ea_lo      <= 2'b00;
            regs       <= '{default: '0};
        end else begin
            mem_req <= mem_req_d;
            retire  <= retire_d;
            halted  <= halted_d;
            if (next_state == S_HALT) halt_cause <= cause_d;
            case (state)
                S_FETCH: if (mem_req && mem_ready) instr_out <= mem_rdata;
                S_DECODE: begin
                    op_a <= regs[rs1[AW-1:0]];
                    op_b <= regs[rs2[AW-1:0]];
                    imm  <= imm_d;
                end
                S_EXEC: begin
                    wb_val <= exec_val;
                    npc    <= exec_npc;
                    ea_lo  <= ea[1:0];
                    if (next_state == S_MEM) begin
                        mem_addr  <= {ea[31:2], 2'b00};
                        mem_we    <= is_store;
                        mem_be    <= is_store ? st_be : 4'b1111;
                        mem_wdata <= st_wdata;
                    end
                end
                S_MEM: if (mem_req && mem_ready && is_load) wb_val <= ld_val;
                S_WB: begin
                    pc_out   <= npc;
                    mem_addr <= {npc[31:2], 2'b00};
                    mem_we   <= 1'b0;
                    mem_be   <= 4'b1111;
                    if (wr_rd && (rd != 5'd0)) regs[rd[AW-1:0]] <= wb_val;
                end
                default: ;
            endcase
        end
    end

    assign dbg_rdata = ((dbg_raddr == 5'd0) || (RV32E && dbg_raddr[4])) ? '0
                     : regs[dbg_raddr[AW-1:0]];
endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Directed bench for rv32i_multicycle_core: small programs in a word memory,
// hand-computed register, lane, timing and halt expectations.
module tb_rv32i_multicycle_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instr_out, dbg_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  halt_cause;
    logic [4:0]  dbg_raddr = 5'd0;

    logic        e_req, e_we, e_retire, e_halted;
    logic [31:0] e_addr, e_wdata, e_pc, e_instr, e_dbg;
    logic [3:0]  e_be;
    logic [1:0]  e_cause;
    logic [4:0]  e_raddr = 5'd20;

    always #5 clk = ~clk;

    rv32i_multicycle_core dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc_out(pc_out), .instr_out(instr_out), .retire(retire), .halted(halted),
        .halt_cause(halt_cause), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    // RV32E instance always fetches addi x20,x0,1
    rv32i_multicycle_core #(.NUM_REGS(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr),
        .mem_be(e_be), .mem_wdata(e_wdata), .mem_ready(1'b1), .mem_rdata(32'h00100A13),
        .pc_out(e_pc), .instr_out(e_instr), .retire(e_retire), .halted(e_halted),
        .halt_cause(e_cause), .dbg_raddr(e_raddr), .dbg_rdata(e_dbg)
    );

    logic [31:0] mem [64];
    logic        ready_en = 1'b1;
    logic        ld_en = 1'b0, clr_en = 1'b0;
    logic [5:0]  ld_idx = 6'd0;
    logic [31:0] ld_word = '0;
    logic [3:0]  st_be = '0;
    logic [31:0] st_wdata = '0, st_addr = '0;
    int          hs_count = 0;

    assign mem_ready = ready_en;
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (clr_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_idx] <= ld_word;
        end else if (mem_req && mem_ready) begin
            hs_count <= hs_count + 1;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                st_be    <= mem_be;
                st_wdata <= mem_wdata;
                st_addr  <= mem_addr;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hold_reset();
        rst_n  = 1'b0;
        clr_en = 1'b1;
        @(posedge clk);
        #1 clr_en = 1'b0;
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        ld_idx  = 6'(idx);
        ld_word = w;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_retire(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (retire) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({tag, "_timeout"}, 32'(retire), 32'd1);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        for (int i = 0; i < budget && !halted; i++) step();
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dbg_raddr = idx;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    int at;
    int hs0;

    initial begin
        // Two dependent ADDIs, ready tied high, then ECALL
        hold_reset();
        put(0, 32'h00500093);
        put(1, 32'hFFD08113);
        put(2, 32'h00000073);
        check("rst_pc", pc_out, 32'h0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cause", 32'(halt_cause), 32'd0);
        release_reset();
        wait_retire("addi1", 20, at);
        check("addi1_cycle", 32'(at), 32'd4);
        wait_retire("addi2", 20, at);
        check("addi2_cycle", 32'(at), 32'd8);
        wait_halt("ecall", 20);
        check("ecall_cause", 32'(halt_cause), 32'd1);
        check("ecall_pc", pc_out, 32'h8);
        check("halt_req", 32'(mem_req), 32'd0);
        check_reg("x1", 5'd1, 32'd5);
        check_reg("x2", 5'd2, 32'd2);
        check_reg("x0", 5'd0, 32'd0);
        check("e_halted", 32'(e_halted), 32'd1);
        check("e_cause", 32'(e_cause), 32'd2);
        check("e_pc", e_pc, 32'h0);
        check("e_instr", e_instr, 32'h00100A13);
        check("e_x20", e_dbg, 32'h0);

        // Fetch held off for three cycles, then reset dropped mid-fetch
        hold_reset();
        put(0, 32'h00500093);
        put(1, 32'hFFD08113);
        put(2, 32'h00000073);
        ready_en = 1'b0;
        release_reset();
        for (int i = 0; i < 4; i++) step();
        check("stall_addr", mem_addr, 32'h0);
        check("stall_req", 32'(mem_req), 32'd1);
        check("stall_retire", 32'(retire), 32'd0);
        ready_en = 1'b1;
        wait_retire("stall", 20, at);
        check("stall_cycle", 32'(at), 32'd7);
        ready_en = 1'b0;
        step();
        check("fetch2_addr", mem_addr, 32'h4);
        check("fetch2_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", 32'(mem_req), 32'd0);
        check("async_pc", pc_out, 32'h0);
        ready_en = 1'b1;
        release_reset();
        step();
        check("refetch_addr", mem_addr, 32'h0);
        check("refetch_req", 32'(mem_req), 32'd1);
        wait_retire("refetch", 20, at);
        check("refetch_cycle", 32'(at), 32'd4);

        // Byte store lanes and sign/zero-extended sub-word loads
        hold_reset();
        put(0, 32'h08000293);
        put(1, 32'h005001A3);
        put(2, 32'h00300303);
        put(3, 32'h00304383);
        put(4, 32'h00201403);
        put(5, 32'h00000073);
        release_reset();
        wait_retire("li_x5", 20, at);
        wait_retire("sb", 20, at);
        check("sb_cycle", 32'(at), 32'd9);
        check("sb_be", 32'(st_be), 32'h8);
        check("sb_wdata", st_wdata, 32'h80808080);
        check("sb_addr", st_addr, 32'h0);
        wait_halt("lanes", 60);
        check("lanes_cause", 32'(halt_cause), 32'd1);
        check("lanes_pc", pc_out, 32'h14);
        check_reg("x5", 5'd5, 32'h00000080);
        check_reg("lb_x6", 5'd6, 32'hFFFFFF80);
        check_reg("lbu_x7", 5'd7, 32'h00000080);
        check_reg("lh_x8", 5'd8, 32'hFFFF8000);

        // jal x0,+16 ; beq x0,x0,-8 at 0x10 ; jal x1,+16 at 0x08
        hold_reset();
        put(0, 32'h0100006F);
        put(4, 32'hFE000CE3);
        put(2, 32'h010000EF);
        put(6, 32'h00000073);
        release_reset();
        wait_retire("jal0", 20, at);
        check("jal0_cycle", 32'(at), 32'd4);
        step();
        check("jal0_pc", pc_out, 32'h10);
        wait_retire("beq", 20, at);
        step();
        check("beq_pc", pc_out, 32'h08);
        wait_retire("jal1", 20, at);
        step();
        check("jal1_pc", pc_out, 32'h18);
        wait_halt("ctrl", 20);
        check_reg("jal_x1", 5'd1, 32'h0000000C);

        // Misaligned word load halts before any data request
        hold_reset();
        put(0, 32'h00700193);
        put(1, 32'h00202183);
        release_reset();
        hs0 = hs_count;
        wait_halt("mis", 30);
        check("mis_cause", 32'(halt_cause), 32'd3);
        check("mis_pc", pc_out, 32'h4);
        check("mis_instr", instr_out, 32'h00202183);
        check("mis_hs", 32'(hs_count - hs0), 32'd2);
        check("mis_req", 32'(mem_req), 32'd0);
        check_reg("mis_x3", 5'd3, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
